sr_unit: RTL and testbench
==========================

SR_UNIT -- requirements
Module: sr_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port reg_SR_in  input  16  candidate SR value from SR source mux.
REQ-004 SHALL have port MSR  input  1  source select from decoder; 1 = function-unit flags, 0 = register-file word.
REQ-005 SHALL have port sr_we  input  1  SR write strobe from decoder.
REQ-006 SHALL have port flag_mask  input  4  per-flag update enables {V,N,Z,C}, used when MSR=1.
REQ-007 SHALL have port reti  input  1  RETI restore strobe.
REQ-008 SHALL have port reti_sr  input  16  SR word popped from stack.
REQ-009 SHALL have port irq_req  input  1  level interrupt request.
REQ-010 SHALL have port irq_ack  output  1  one-cycle pulse, interrupt entry complete.
REQ-011 SHALL have port push_valid  output  1  saved SR available for stack push.
REQ-012 SHALL have port push_ready  input  1  stack accepts push.
REQ-013 SHALL have port push_data  output  16  saved SR snapshot.
REQ-014 SHALL have port reg_SR_out  output  16  current SR.
REQ-015 SHALL have port stall  output  1  high whenever state is not RUN.
REQ-016 SHALL have ports gie, cpu_off  output  1 each  direct copies of SR[3], SR[4].

Function
REQ-017 SR bit map SHALL be C=0, Z=1, N=2, GIE=3, CPUOFF=4, OSCOFF=5, SCG0=6, SCG1=7, V=8; bits 15:9 SHALL always read 0 and never be stored non-zero.
REQ-018 FSM SHALL have states RUN, PUSH, CLR; reg_SR_out SHALL be registered, updated one cycle after the accepted strobe.
REQ-019 In RUN, priority SHALL be reti > sr_we > interrupt entry; only the highest active source acts that cycle.
REQ-020 reti in RUN: SR <= reti_sr & 16'h01FF.
REQ-021 sr_we with MSR=0: SR <= reg_SR_in & 16'h01FF.
REQ-022 sr_we with MSR=1: only bits C, Z, N, V whose flag_mask bit is 1 take reg_SR_in values; all other bits hold.
REQ-023 Interrupt entry SHALL be accepted in RUN only when irq_req=1, SR[3]=1, reti=0, sr_we=0; otherwise deferred (level input, re-evaluated each cycle).
REQ-024 On acceptance: push_data <= SR, state -> PUSH.
REQ-025 PUSH: push_valid=1, push_data stable; on push_valid & push_ready state -> CLR; push_data unchanged until handshake.
REQ-026 CLR: SR <= SR & 16'h0040 (all cleared except SCG0, so GIE=0, CPUOFF=0 wake), irq_ack=1 for that cycle, state -> RUN.
REQ-027 In PUSH and CLR, sr_we and reti SHALL be ignored (no SR change); stall=1.
REQ-028 irq_req dropping during PUSH SHALL NOT abort the sequence.
REQ-029 push_ready high in the first PUSH cycle SHALL give minimum entry latency: accept cycle N, PUSH N+1, CLR N+2, irq_ack at N+2, new SR visible N+3.
REQ-030 push_valid, irq_ack, stall SHALL be combinational decodes of state only.

Reset
REQ-031 rst=1 at a clock edge SHALL force state RUN, SR=16'h0000, push_data=16'h0000, regardless of state, including mid-PUSH/CLR.
REQ-032 During and after reset: push_valid=0, irq_ack=0, stall=0, gie=0, cpu_off=0 until SR is written.

Verification
REQ-033 Full write: sr_we=1, MSR=0, reg_SR_in=16'hFFFF -> reg_SR_out=16'h01FF next cycle.
REQ-034 Masked write: SR=16'h0000, sr_we=1, MSR=1, flag_mask=4'b0101, reg_SR_in=16'h01FF -> SR=16'h0005 (C, N set).
REQ-035 Entry: SR=16'h0058, irq_req=1, push_ready=1 -> push_data=16'h0058 with push_valid one cycle, irq_ack next cycle, SR=16'h0040, cpu_off=0.
REQ-036 Backpressure: push_ready=0 for 3 cycles in PUSH, sr_we pulsed -> push_valid held, push_data stable, SR unchanged, irq_ack only after ready.
REQ-037 Collision: reti (reti_sr=16'h0008) and irq_req same cycle with SR GIE=0 -> SR=16'h0008, entry starts next cycle.
REQ-038 Reset mid-PUSH: rst=1 while push_valid=1 -> state RUN, SR=0, push_valid=0, no irq_ack.

Source files
------------

// File: rtl/sr_unit.sv
// Status register unit: holds the 9 architected SR bits, applies decoder writes and
// RETI restores, and sequences interrupt entry (snapshot push, then SR clear + ack).
module sr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] reg_SR_in,
    input  logic        MSR,
    input  logic        sr_we,
    input  logic [3:0]  flag_mask,
    input  logic        reti,
    input  logic [15:0] reti_sr,
    input  logic        irq_req,
    output logic        irq_ack,
    output logic        push_valid,
    input  logic        push_ready,
    output logic [15:0] push_data,
    output logic [15:0] reg_SR_out,
    output logic        stall,
    output logic        gie,
    output logic        cpu_off
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PUSH = 2'd1,
        CLR  = 2'd2
    } state_t;

    localparam int unsigned BIT_C      = 0;
    localparam int unsigned BIT_Z      = 1;
    localparam int unsigned BIT_N      = 2;
    localparam int unsigned BIT_GIE    = 3;
    localparam int unsigned BIT_CPUOFF = 4;
    localparam int unsigned BIT_V      = 8;

    // Only bits 8:0 exist; the upper SR bits are tied to zero on the outputs.
    localparam logic [8:0] CLR_KEEP = 9'h040;

    state_t     state_q, state_d;
    logic [8:0] sr_q, sr_d;
    logic [8:0] push_data_q, push_data_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        sr_d        = sr_q;
        push_data_d = push_data_q;

        unique case (state_q)
            RUN: begin
                if (reti) begin
                    sr_d = reti_sr[8:0];
                end else if (sr_we) begin
                    if (!MSR) begin
                        sr_d = reg_SR_in[8:0];
                    end else begin
                        if (flag_mask[0]) sr_d[BIT_C] = reg_SR_in[BIT_C];
                        if (flag_mask[1]) sr_d[BIT_Z] = reg_SR_in[BIT_Z];
                        if (flag_mask[2]) sr_d[BIT_N] = reg_SR_in[BIT_N];
                        if (flag_mask[3]) sr_d[BIT_V] = reg_SR_in[BIT_V];
                    end
                end else if (irq_req && sr_q[BIT_GIE]) begin
                    push_data_d = sr_q;
                    state_d     = PUSH;
                end
            end
            PUSH: begin
                if (push_ready) state_d = CLR;
            end
            CLR: begin
                // Entry wakes the CPU and masks interrupts; only SCG0 survives.
                sr_d    = sr_q & CLR_KEEP;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= RUN;
            sr_q        <= 9'h000;
            push_data_q <= 9'h000;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            push_data_q <= push_data_d;
        end
    end

    assign push_valid = (state_q == PUSH);
    assign irq_ack    = (state_q == CLR);
    assign stall      = (state_q != RUN);
    assign reg_SR_out = {7'b0, sr_q};
    assign push_data  = {7'b0, push_data_q};
    assign gie        = sr_q[BIT_GIE];
    assign cpu_off    = sr_q[BIT_CPUOFF];

endmodule

// File: tb/tb_sr_unit.sv
// Scoreboard bench for sr_unit: directed scenarios plus random traffic against a
// cycle-level behavioural model of the SR rules; a negedge monitor compares outputs.
module tb_sr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] reg_SR_in;
    logic        MSR;
    logic        sr_we;
    logic [3:0]  flag_mask;
    logic        reti;
    logic [15:0] reti_sr;
    logic        irq_req;
    logic        irq_ack;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_data;
    logic [15:0] reg_SR_out;
    logic        stall;
    logic        gie;
    logic        cpu_off;

    always #5 clk = ~clk;

    sr_unit dut (
        .clk        (clk),
        .rst        (rst),
        .reg_SR_in  (reg_SR_in),
        .MSR        (MSR),
        .sr_we      (sr_we),
        .flag_mask  (flag_mask),
        .reti       (reti),
        .reti_sr    (reti_sr),
        .irq_req    (irq_req),
        .irq_ack    (irq_ack),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .reg_SR_out (reg_SR_out),
        .stall      (stall),
        .gie        (gie),
        .cpu_off    (cpu_off)
    );

    typedef struct {
        logic [15:0] sr;
        logic [15:0] pd;
        logic        pv;
        logic        ack;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: the SR word, the saved snapshot, and where the entry sequence stands.
    logic [15:0] m_sr    = 16'h0000;
    logic [15:0] m_saved = 16'h0000;
    bit          m_awaiting_push = 1'b0;
    bit          m_ack_due       = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        int flag_pos[4] = '{0, 1, 2, 8};
        if (rst) begin
            m_sr = 16'h0000; m_saved = 16'h0000;
            m_awaiting_push = 1'b0; m_ack_due = 1'b0;
        end else if (m_ack_due) begin
            m_sr      = m_sr & 16'h0040;
            m_ack_due = 1'b0;
        end else if (m_awaiting_push) begin
            if (push_ready) begin
                m_awaiting_push = 1'b0;
                m_ack_due       = 1'b1;
            end
        end else if (reti) begin
            m_sr = reti_sr & 16'h01FF;
        end else if (sr_we) begin
            if (!MSR) m_sr = reg_SR_in & 16'h01FF;
            else
                for (int i = 0; i < 4; i++)
                    if (flag_mask[i]) m_sr[flag_pos[i]] = reg_SR_in[flag_pos[i]];
        end else if (irq_req && m_sr[3]) begin
            m_saved         = m_sr;
            m_awaiting_push = 1'b1;
        end
    endtask

    // One clock cycle: apply inputs, advance the model, queue what the DUT must show after the edge.
    task automatic drive(input bit r, input bit rt, input logic [15:0] rsr, input bit we,
                         input bit msr_i, input logic [3:0] m, input logic [15:0] din,
                         input bit irq, input bit rdy);
        exp_t e;
        rst = r; reti = rt; reti_sr = rsr; sr_we = we; MSR = msr_i;
        flag_mask = m; reg_SR_in = din; irq_req = irq; push_ready = rdy;
        model_step();
        e.sr = m_sr; e.pd = m_saved; e.pv = m_awaiting_push;
        e.ack = m_ack_due; e.stall = m_awaiting_push | m_ack_due;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit irq, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, irq, rdy);
    endtask

    task automatic write_sr(input logic [15:0] v);
        drive(0, 0, 16'h0, 1, 0, 4'h0, v, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reg_SR_out", reg_SR_out, e.sr);
                check("push_valid", {15'b0, push_valid}, {15'b0, e.pv});
                check("push_data",  push_data, e.pd);
                check("irq_ack",    {15'b0, irq_ack}, {15'b0, e.ack});
                check("stall",      {15'b0, stall}, {15'b0, e.stall});
                check("gie",        {15'b0, gie}, {15'b0, e.sr[3]});
                check("cpu_off",    {15'b0, cpu_off}, {15'b0, e.sr[4]});
            end
        end
    end

    initial begin : stimulus
        int budget;
        rst = 1'b1; reti = 0; reti_sr = 0; sr_we = 0; MSR = 0;
        flag_mask = 0; reg_SR_in = 0; irq_req = 0; push_ready = 0;

        // Reset state.
        drive(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 0, 0);
        drive(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 1, 1);
        idle(1, 0, 0);

        // Full write clips to 9 bits.
        write_sr(16'hFFFF);
        idle(1, 0, 0);

        // Masked flag write: C and N only.
        write_sr(16'h0000);
        drive(0, 0, 16'h0, 1, 1, 4'b0101, 16'h01FF, 0, 0);
        drive(0, 0, 16'h0, 1, 1, 4'b1010, 16'hFFFF, 0, 0);
        idle(1, 0, 0);

        // Minimum-latency interrupt entry.
        write_sr(16'h0058);
        drive(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 1, 1);
        idle(4, 0, 1);

        // Backpressure with writes pulsed during PUSH, irq dropped mid-sequence.
        write_sr(16'h0008);
        drive(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 1, 0);
        drive(0, 0, 16'h0, 1, 0, 4'h0, 16'hFFFF, 0, 0);
        drive(0, 1, 16'h01FF, 0, 0, 4'h0, 16'h0, 0, 0);
        drive(0, 0, 16'h0, 1, 1, 4'hF, 16'hFFFF, 0, 0);
        idle(3, 0, 1);

        // RETI wins over a pending interrupt; entry follows once GIE is restored.
        write_sr(16'h0000);
        drive(0, 1, 16'h0008, 0, 0, 4'h0, 16'h0, 1, 1);
        idle(4, 1, 1);
        idle(2, 0, 0);

        // Reset while the push is outstanding.
        write_sr(16'h0008);
        drive(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 1, 0);
        idle(1, 0, 0);
        drive(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 0, 1);
        idle(3, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) == 0),
                  16'($urandom),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom),
                  4'($urandom),
                  16'($urandom),
                  ($urandom_range(0, 2) != 0),
                  1'($urandom));
        end
        idle(2, 0, 1);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: actual=%0d entries left required=0", exp_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
